engine_ctrl_multi: RTL and testbench
====================================

Name: engine_ctrl_multi

Overview:
Parametrised successor to the single-channel engine controller. It handles CHANNELS independent button/sense pairs, with per-channel input debounce, a sense-acknowledge timeout, and a latched fault state. A global limit of MAX_ACTIVE allows only that many motors to run at once, and free slots go to channels by fixed priority. The block sits between the operator panel and sensor inputs and the motor drivers.

Parameters:
CHANNELS, 4, number of independent engine channels (1..16)
DEBOUNCE, 3, consecutive cycles a raw input must differ from its filtered value before the filtered value flips (>=1)
SENSE_TIMEOUT, 8, cycles allowed in ARMED without filtered sense before FAULT (>=1)
MAX_ACTIVE, 2, maximum channels simultaneously in RUN (1..CHANNELS)
RUN_LIMIT, 64, maximum consecutive RUN cycles; used only with ENGINE_RUN_LIMIT_EN

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clock edge
button  input  CHANNELS  raw start request per channel, asynchronous to logic intent, debounced internally
sense  input  CHANNELS  raw engine-running sensor per channel
enable  output  CHANNELS  channel armed or running (ARMED or RUN)
motor  output  CHANNELS  motor drive (RUN only)
fault  output  CHANNELS  channel in FAULT
active_count  output  $clog2(CHANNELS+1)  number of channels currently in RUN

Behaviour:
- Reset (reset==0 at an edge): every channel goes to IDLE. Filtered inputs, debounce counters and timers clear to 0. enable, motor, fault and active_count are all 0 after that edge. This overrides any mid-operation state, so a running motor drops at that edge.
- Debounce, per input bit: counter clears when raw==filtered. Otherwise it increments. On the edge where it would reach DEBOUNCE, filtered takes raw and the counter clears. With DEBOUNCE=1 the filter is a single register stage.
- All outputs decode directly from registered state (Moore). There is no combinational path from inputs to outputs.
- Per-channel FSM, with btn_f and sns_f as the filtered inputs:
  - IDLE: enable=0, motor=0, fault=0. If btn_f=1, go to ARMED and clear the timer.
  - ARMED: enable=1.
    - If btn_f=0, go to IDLE. This has highest priority.
    - Else if sns_f=1 and a grant is present, go to RUN.
    - Else if sns_f=0 and timer==SENSE_TIMEOUT-1, go to FAULT.
    - Otherwise stay. The timer increments only while sns_f=0 and holds while sns_f=1 and the channel is waiting for a grant.
  - RUN: enable=1, motor=1.
    - If btn_f=0, go to IDLE. If btn_f=0 and sns_f=0 in the same cycle, IDLE wins.
    - Else if sns_f=0, go to FAULT (engine lost).
  - FAULT: fault=1, enable=0, motor=0. Go to IDLE only when btn_f=0 and sns_f=0 in the same cycle. Otherwise hold.
- Grant arbitration is evaluated each cycle from current state:
  - free = MAX_ACTIVE − (number of channels in RUN now).
  - Candidates are channels in ARMED with sns_f=1 and btn_f=1.
  - Grants go to the free lowest-index candidates.
  - A slot freed by a channel leaving RUN becomes available on the following cycle, not the same one.
  - active_count never exceeds MAX_ACTIVE.
- Latency: a raw button rise held stable produces btn_f after DEBOUNCE edges, and enable rises on the next edge.
- Timeout: FAULT is entered SENSE_TIMEOUT edges after ARMED entry if sns_f stays 0 throughout.

Optional Feature:
ENGINE_RUN_LIMIT_EN
- Defined: a per-channel run timer clears on RUN entry and increments each RUN cycle. When it reaches RUN_LIMIT-1 and no other exit applies, the channel goes to FAULT on the next edge, so motor is high for exactly RUN_LIMIT cycles.
- Undefined: RUN has no time limit, and neither the timer nor RUN_LIMIT generates logic.

Test Plan:
- Reset: drive reset=0 for 2 edges with all inputs at 1 -> all outputs 0. Release, keep button0=0 -> outputs stay 0.
- Nominal start/stop, defaults:
  - button0 rises stable -> enable[0]=1 four edges later.
  - sense0 rises 2 cycles after that -> motor[0]=1 four edges after the sense rise.
  - button0 falls -> motor[0]=0 and enable[0]=0 four edges after the fall.
- Debounce glitch: 2-cycle pulse on button1 -> enable[1] never asserts. 3-cycle pulse -> enable[1] asserts.
- Sense timeout and fault recovery:
  - button2 held, sense2=0 -> fault[2]=1 exactly 8 edges after enable[2] rises.
  - Release button2 -> fault[2] clears after debounce plus 1 edge.
  - Release with sense2 still 1 -> fault[2] holds.
- MAX_ACTIVE=2 arbitration:
  - All 4 channels armed with sense high -> motor=0011, active_count=2.
  - Drop button0 -> after debounce, motor[0] falls and motor[2] rises one edge later. active_count stays ≤2 throughout.
- Mid-run loss and reset:
  - sense3 falls while motor[3]=1 -> fault[3]=1 after debounce plus 1.
  - reset=0 during RUN on other channels -> all outputs 0 on that edge.
  - With ENGINE_RUN_LIMIT_EN and RUN_LIMIT=64 -> motor high for exactly 64 cycles, then fault=1.

Source files
------------

// File: rtl/engine_ctrl_multi.sv
// Multi-channel engine controller: debounce, sense timeout, latched fault, MAX_ACTIVE arbitration.
// Optional run-time limit enabled by defining ENGINE_RUN_LIMIT_EN.
module engine_ctrl_multi #(
  parameter int CHANNELS      = 4,
  parameter int DEBOUNCE      = 3,
  parameter int SENSE_TIMEOUT = 8,
  parameter int MAX_ACTIVE    = 2,
  parameter int RUN_LIMIT     = 64
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [CHANNELS-1:0]               button,
  input  logic [CHANNELS-1:0]               sense,
  output logic [CHANNELS-1:0]               enable,
  output logic [CHANNELS-1:0]               motor,
  output logic [CHANNELS-1:0]               fault,
  output logic [$clog2(CHANNELS+1)-1:0]     active_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_FAULT
  } state_t;

  localparam int CW = $clog2(CHANNELS+1);
  localparam int DW = $clog2(DEBOUNCE+1);
  localparam int TW = (SENSE_TIMEOUT > 1) ? $clog2(SENSE_TIMEOUT) : 1;

  logic [CHANNELS-1:0] btn_f;
  logic [CHANNELS-1:0] sns_f;
  logic [CHANNELS-1:0] grant;
  logic [DW-1:0]       bcnt [CHANNELS];
  logic [DW-1:0]       scnt [CHANNELS];
  state_t              st_q [CHANNELS];
  state_t              st_d [CHANNELS];
  logic [TW-1:0]       tm_q [CHANNELS];
  logic [TW-1:0]       tm_d [CHANNELS];
  logic [CW-1:0]       nrun;
  logic [CW-1:0]       gcnt;

`ifdef ENGINE_RUN_LIMIT_EN
  localparam int RW = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
  logic [RW-1:0]       rt_q [CHANNELS];
  logic [RW-1:0]       rt_d [CHANNELS];
`else
  if (RUN_LIMIT < 1) begin : g_unused_limit
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_f <= '0;
      sns_f <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        bcnt[i] <= '0;
        scnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (button[i] == btn_f[i]) begin
          bcnt[i] <= '0;
        end else if (bcnt[i] == DW'(DEBOUNCE-1)) begin
          btn_f[i] <= button[i];
          bcnt[i]  <= '0;
        end else begin
          bcnt[i] <= bcnt[i] + DW'(1);
        end
        if (sense[i] == sns_f[i]) begin
          scnt[i] <= '0;
        end else if (scnt[i] == DW'(DEBOUNCE-1)) begin
          sns_f[i] <= sense[i];
          scnt[i]  <= '0;
        end else begin
          scnt[i] <= scnt[i] + DW'(1);
        end
      end
    end
  end

  // Slots freed this cycle only count next cycle: grants use current state
  always_comb begin
    nrun  = '0;
    grant = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (st_q[i] == S_RUN) nrun = nrun + CW'(1);
    gcnt = nrun;
    for (int i = 0; i < CHANNELS; i++) begin
      if (st_q[i] == S_ARMED && btn_f[i] && sns_f[i] &&
          gcnt < CW'(MAX_ACTIVE)) begin
        grant[i] = 1'b1;
        gcnt     = gcnt + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      st_d[i] = st_q[i];
      tm_d[i] = tm_q[i];
`ifdef ENGINE_RUN_LIMIT_EN
      rt_d[i] = rt_q[i];
`endif
      unique case (st_q[i])
        S_IDLE: begin
          if (btn_f[i]) begin
            st_d[i] = S_ARMED;
            tm_d[i] = '0;
          end
        end
        S_ARMED: begin
          if (!btn_f[i]) begin
            st_d[i] = S_IDLE;
          end else if (sns_f[i] && grant[i]) begin
            st_d[i] = S_RUN;
`ifdef ENGINE_RUN_LIMIT_EN
            rt_d[i] = '0;
`endif
          end else if (!sns_f[i]) begin
            if (tm_q[i] == TW'(SENSE_TIMEOUT-1)) st_d[i] = S_FAULT;
            else tm_d[i] = tm_q[i] + TW'(1);
          end
        end
        S_RUN: begin
          if (!btn_f[i]) begin
            st_d[i] = S_IDLE;
          end else if (!sns_f[i]) begin
            st_d[i] = S_FAULT;
`ifdef ENGINE_RUN_LIMIT_EN
          end else if (rt_q[i] == RW'(RUN_LIMIT-1)) begin
            st_d[i] = S_FAULT;
          end else begin
            rt_d[i] = rt_q[i] + RW'(1);
`endif
          end
        end
        S_FAULT: begin
          if (!btn_f[i] && !sns_f[i]) st_d[i] = S_IDLE;
        end
        default: st_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!reset) begin
        st_q[i] <= S_IDLE;
        tm_q[i] <= '0;
`ifdef ENGINE_RUN_LIMIT_EN
        rt_q[i] <= '0;
`endif
      end else begin
        st_q[i] <= st_d[i];
        tm_q[i] <= tm_d[i];
`ifdef ENGINE_RUN_LIMIT_EN
        rt_q[i] <= rt_d[i];
`endif
      end
    end
  end

  always_comb begin
    enable = '0;
    motor  = '0;
    fault  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      enable[i] = (st_q[i] == S_ARMED) || (st_q[i] == S_RUN);
      motor[i]  = (st_q[i] == S_RUN);
      fault[i]  = (st_q[i] == S_FAULT);
    end
  end

  assign active_count = nrun;

endmodule

// File: tb/tb_engine_ctrl_multi.sv
// Randomized + directed bench for engine_ctrl_multi against a behavioural model.
// Model follows ENGINE_RUN_LIMIT_EN the same way the design does.
module tb_engine_ctrl_multi;

  localparam int CH = 4;
  localparam int DB = 3;
  localparam int TO = 8;
  localparam int MA = 2;
  localparam int RL = 64;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] sense = '0;
  logic [CH-1:0] enable;
  logic [CH-1:0] motor;
  logic [CH-1:0] fault;
  logic [$clog2(CH+1)-1:0] active_count;

  int n_cmp = 0;
  int n_bad = 0;

  int mode   [CH];
  int fb     [CH];
  int fs     [CH];
  int cb     [CH];
  int cs     [CH];
  int lowcnt [CH];
  int runcnt [CH];

  engine_ctrl_multi #(
    .CHANNELS(CH), .DEBOUNCE(DB), .SENSE_TIMEOUT(TO),
    .MAX_ACTIVE(MA), .RUN_LIMIT(RL)
  ) dut (
    .clock(clock), .reset(reset), .button(button), .sense(sense),
    .enable(enable), .motor(motor), .fault(fault),
    .active_count(active_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [CH-1:0] b,
                            input logic [CH-1:0] s);
    int free;
    if (!r) begin
      for (int i = 0; i < CH; i++) begin
        mode[i] = M_IDLE;
        fb[i] = 0; fs[i] = 0; cb[i] = 0; cs[i] = 0;
        lowcnt[i] = 0; runcnt[i] = 0;
      end
    end else begin
      free = MA;
      for (int i = 0; i < CH; i++)
        if (mode[i] == M_RUN) free--;
      for (int i = 0; i < CH; i++) begin
        case (mode[i])
          M_IDLE: if (fb[i] != 0) begin
            mode[i] = M_ARMED;
            lowcnt[i] = 0;
          end
          M_ARMED: begin
            if (fb[i] == 0) mode[i] = M_IDLE;
            else if (fs[i] != 0 && free > 0) begin
              free--;
              mode[i] = M_RUN;
              runcnt[i] = 0;
            end else if (fs[i] == 0) begin
              lowcnt[i]++;
              if (lowcnt[i] >= TO) mode[i] = M_FAULT;
            end
          end
          M_RUN: begin
            if (fb[i] == 0) mode[i] = M_IDLE;
            else if (fs[i] == 0) mode[i] = M_FAULT;
`ifdef ENGINE_RUN_LIMIT_EN
            else begin
              runcnt[i]++;
              if (runcnt[i] >= RL) mode[i] = M_FAULT;
            end
`endif
          end
          default: if (fb[i] == 0 && fs[i] == 0) mode[i] = M_IDLE;
        endcase
      end
      for (int i = 0; i < CH; i++) begin
        if (int'(b[i]) != fb[i]) begin
          cb[i]++;
          if (cb[i] == DB) begin fb[i] = int'(b[i]); cb[i] = 0; end
        end else cb[i] = 0;
        if (int'(s[i]) != fs[i]) begin
          cs[i]++;
          if (cs[i] == DB) begin fs[i] = int'(s[i]); cs[i] = 0; end
        end else cs[i] = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [CH-1:0] b,
                     input logic [CH-1:0] s);
    int e, m, f, a;
    reset = r; button = b; sense = s;
    @(posedge clock);
    model_edge(r, b, s);
    @(negedge clock);
    e = 0; m = 0; f = 0; a = 0;
    for (int i = 0; i < CH; i++) begin
      if (mode[i] == M_ARMED || mode[i] == M_RUN) e |= (1 << i);
      if (mode[i] == M_RUN) begin m |= (1 << i); a++; end
      if (mode[i] == M_FAULT) f |= (1 << i);
    end
    check("enable", int'(enable), e);
    check("motor", int'(motor), m);
    check("fault", int'(fault), f);
    check("active_count", int'(active_count), a);
    check("cap", int'(active_count <= MA), 1);
  endtask

  initial begin
    logic [CH-1:0] b, s;
    int k, seen;
    @(negedge clock);
    repeat (2) cyc(1'b0, '1, '1);
    check("rst_out", int'(enable | motor | fault), 0);
    repeat (3) cyc(1'b1, '0, '0);
    check("idle_out", int'(enable | motor | fault), 0);

    b = 4'b0001; s = 4'b0000;
    repeat (3) cyc(1'b1, b, s);
    check("en0_early", int'(enable[0]), 0);
    cyc(1'b1, b, s);
    check("en0_rise", int'(enable[0]), 1);
    repeat (2) cyc(1'b1, b, s);
    s = 4'b0001;
    repeat (3) cyc(1'b1, b, s);
    check("m0_early", int'(motor[0]), 0);
    cyc(1'b1, b, s);
    check("m0_rise", int'(motor[0]), 1);
    b = 4'b0000;
    repeat (3) cyc(1'b1, b, s);
    check("m0_hold", int'(motor[0]), 1);
    cyc(1'b1, b, s);
    check("m0_fall", int'(motor[0] | enable[0]), 0);
    repeat (5) cyc(1'b1, '0, '0);

    seen = 0;
    repeat (2) begin cyc(1'b1, 4'b0010, '0); seen |= int'(enable[1]); end
    repeat (8) begin cyc(1'b1, '0, '0); seen |= int'(enable[1]); end
    check("glitch2", seen, 0);
    repeat (3) begin cyc(1'b1, 4'b0010, '0); seen |= int'(enable[1]); end
    repeat (8) begin cyc(1'b1, '0, '0); seen |= int'(enable[1]); end
    check("pulse3", seen, 1);

    b = 4'b0100;
    k = 0;
    while (!enable[2] && k < 10) begin cyc(1'b1, b, '0); k++; end
    check("en2_lat", k, 4);
    k = 0;
    while (!fault[2] && k < 20) begin cyc(1'b1, b, '0); k++; end
    check("timeout", k, TO);
    k = 0;
    while (fault[2] && k < 20) begin cyc(1'b1, '0, '0); k++; end
    check("fault_clr", k, DB + 1);
    k = 0;
    while (!fault[2] && k < 30) begin cyc(1'b1, b, '0); k++; end
    repeat (10) cyc(1'b1, '0, 4'b0100);
    check("fault_hold", int'(fault[2]), 1);
    repeat (6) cyc(1'b1, '0, '0);

    repeat (10) cyc(1'b1, 4'b1111, 4'b1111);
    check("arb_motor", int'(motor), 3);
    check("arb_count", int'(active_count), 2);
    repeat (8) cyc(1'b1, 4'b1110, 4'b1111);
    check("arb_swap", int'(motor), 6);
    repeat (6) cyc(1'b1, 4'b1110, 4'b0111);
    cyc(1'b0, 4'b1110, 4'b0111);
    repeat (4) cyc(1'b1, '0, '0);

    b = '0; s = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(9) == 0) b[i] = ~b[i];
        if ($urandom_range(9) == 0) s[i] = ~s[i];
      end
      cyc(($urandom_range(299) != 0), b, s);
    end

`ifdef ENGINE_RUN_LIMIT_EN
    repeat (2) cyc(1'b0, '0, '0);
    k = 0;
    while (!motor[0] && k < 20) begin cyc(1'b1, 4'b0001, 4'b0001); k++; end
    k = 0;
    while (motor[0] && k < RL + 10) begin cyc(1'b1, 4'b0001, 4'b0001); k++; end
    check("run_limit", k, RL);
    check("run_limit_fault", int'(fault[0]), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
